// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared definitions for the 8x8 signed shift-add multiplier:
//               default operand width and the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

   // Default operand width; the product is 2*MULT_N bits wide.
   localparam int MULT_N = 8;

   // One add step and one shift step per multiplier bit.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADD   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mult_ctrl
// Description : Sequencer for the shift-add multiplier. Walks ADD/SHIFT once
//               per multiplier bit using step counter K and issues the
//               register-control strobes for the datapath.
// Ports       : Clk, Reset_n        - clock, async active-low reset
//               run, clear_a_load_b - level requests from the board
//               b_lsb               - current multiplier bit B[0]
//               start, load_b       - IDLE decodes (same-cycle with request)
//               load_xa, shift      - datapath update strobes
//               fn                  - adder subtract select
//               busy, done          - status
// Revision    : 1.0 - initial release
// ============================================================================
module mult_ctrl
   import mult_pkg::*;
#(
   parameter int N = MULT_N
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic run,
   input  logic clear_a_load_b,
   input  logic b_lsb,
   output logic start,
   output logic load_b,
   output logic load_xa,
   output logic shift,
   output logic fn,
   output logic busy,
   output logic done
);

   localparam int              KW         = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0]   C_K_LAST   = KW'(N - 1);
   localparam logic [KW-1:0]   C_K_ONE    = KW'(1);

   state_t          r_state;
   logic [KW-1:0]   r_k;
   logic            r_add;
   logic            r_shift;
   logic            r_fn;
   logic            r_busy;
   logic            r_done;

   // start/load_b must act on the same edge that samples the request, so
   // they are decoded from the registered state rather than registered again.
   assign start   = (r_state == IDLE) &  run;
   assign load_b  = (r_state == IDLE) & ~run & clear_a_load_b;
   // Only add when the current multiplier bit is set.
   assign load_xa = r_add & b_lsb;
   assign shift   = r_shift;
   assign fn      = r_fn;
   assign busy    = r_busy;
   assign done    = r_done;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= IDLE;
         r_k     <= '0;
         r_add   <= 1'b0;
         r_shift <= 1'b0;
         r_fn    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (run) begin
                  r_state <= ADD;
                  r_k     <= '0;
                  r_add   <= 1'b1;
                  r_fn    <= (C_K_LAST == '0);
                  r_busy  <= 1'b1;
               end
            end
            ADD: begin
               r_state <= SHIFT;
               r_add   <= 1'b0;
               r_shift <= 1'b1;
               r_fn    <= 1'b0;
            end
            SHIFT: begin
               r_shift <= 1'b0;
               if (r_k == C_K_LAST) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_k     <= r_k + C_K_ONE;
                  r_state <= ADD;
                  r_add   <= 1'b1;
                  // The sign bit of the multiplier carries negative weight,
                  // so the final step subtracts the multiplicand.
                  r_fn    <= ((r_k + C_K_ONE) == C_K_LAST);
               end
            end
            DONE: begin
               // Wait for run to drop so a held button cannot retrigger.
               if (!run) begin
                  r_state <= IDLE;
                  r_done  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_k     <= '0;
               r_add   <= 1'b0;
               r_shift <= 1'b0;
               r_fn    <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule : mult_ctrl
`default_nettype wire

// File: rtl/shift_add_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mult_ctrl
// Description : Control and register stage of the N x N signed shift-add
//               multiplier. Holds the product in X:A:B and the latched
//               multiplicand M, drives the external add/subtract unit and
//               captures its result in the same cycle.
// Ports       : Clk, Reset_n                - clock, async active-low reset
//               run, clear_a_load_b, sw     - board controls and switches
//               addsub_a/_b/_fn, addsub_s   - external adder interface
//               x_out, a_out, b_out         - product registers X:A:B
//               busy, done                  - status
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mult_ctrl
   import mult_pkg::*;
#(
   parameter int N = MULT_N
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         run,
   input  logic         clear_a_load_b,
   input  logic [N-1:0] sw,
   output logic [N-1:0] addsub_a,
   output logic [N-1:0] addsub_b,
   output logic         addsub_fn,
   input  logic [N:0]   addsub_s,
   output logic         x_out,
   output logic [N-1:0] a_out,
   output logic [N-1:0] b_out,
   output logic         busy,
   output logic         done
);

   logic         r_x;
   logic [N-1:0] r_a;
   logic [N-1:0] r_b;
   logic [N-1:0] r_m;

   logic         w_start;
   logic         w_load_b;
   logic         w_load_xa;
   logic         w_shift;

   mult_ctrl #(
      .N (N)
   ) u_ctrl (
      .Clk            (Clk),
      .Reset_n        (Reset_n),
      .run            (run),
      .clear_a_load_b (clear_a_load_b),
      .b_lsb          (r_b[0]),
      .start          (w_start),
      .load_b         (w_load_b),
      .load_xa        (w_load_xa),
      .shift          (w_shift),
      .fn             (addsub_fn),
      .busy           (busy),
      .done           (done)
   );

   // The adder is combinational and outside this block; its result is
   // captured straight back into X:A in the ADD cycle.
   assign addsub_a = r_a;
   assign addsub_b = r_m;

   assign x_out = r_x;
   assign a_out = r_a;
   assign b_out = r_b;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_x <= 1'b0;
         r_a <= '0;
         r_b <= '0;
         r_m <= '0;
      end else if (w_start) begin
         // B is left alone: it already holds the multiplier (or the low
         // half of the previous product for chained runs).
         r_m <= sw;
         r_x <= 1'b0;
         r_a <= '0;
      end else if (w_load_b) begin
         r_x <= 1'b0;
         r_a <= '0;
         r_b <= sw;
      end else if (w_load_xa) begin
         r_x <= addsub_s[N];
         r_a <= addsub_s[N-1:0];
      end else if (w_shift) begin
         // Arithmetic shift of {X,A,B}: X is replicated into A's MSB.
         r_a <= {r_x, r_a[N-1:1]};
         r_b <= {r_a[0], r_b[N-1:1]};
      end
   end

endmodule : shift_add_mult_ctrl
`default_nettype wire

// File: tb/tb_shift_add_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_mult_ctrl
// Description : Self-checking bench for shift_add_mult_ctrl. Supplies the
//               external add/subtract unit and compares products against a
//               signed-multiply reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult_ctrl;

   localparam int N = 8;

   logic         Clk;
   logic         Reset_n;
   logic         run;
   logic         clear_a_load_b;
   logic [N-1:0] sw;
   logic [N-1:0] addsub_a;
   logic [N-1:0] addsub_b;
   logic         addsub_fn;
   logic [N:0]   addsub_s;
   logic         x_out;
   logic [N-1:0] a_out;
   logic [N-1:0] b_out;
   logic         busy;
   logic         done;

   int           total;
   int           bad;
   logic [N-1:0] mb;   // expected contents of B before the next run

   shift_add_mult_ctrl #(.N(N)) dut (
      .Clk            (Clk),
      .Reset_n        (Reset_n),
      .run            (run),
      .clear_a_load_b (clear_a_load_b),
      .sw             (sw),
      .addsub_a       (addsub_a),
      .addsub_b       (addsub_b),
      .addsub_fn      (addsub_fn),
      .addsub_s       (addsub_s),
      .x_out          (x_out),
      .a_out          (a_out),
      .b_out          (b_out),
      .busy           (busy),
      .done           (done)
   );

   // External 9-bit sign-extending add/subtract unit.
   assign addsub_s = addsub_fn ? ({addsub_a[N-1], addsub_a} - {addsub_b[N-1], addsub_b})
                               : ({addsub_a[N-1], addsub_a} + {addsub_b[N-1], addsub_b});

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
      int p;
      p = int'($signed(x)) * int'($signed(y));
      return p[2*N-1:0];
   endfunction

   function automatic logic [N-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return 8'h80;
         1:       return 8'h7F;
         2:       return 8'hFF;
         3:       return 8'h00;
         default: return N'($urandom);
      endcase
   endfunction

   task automatic do_load_b(input logic [N-1:0] v);
      @(negedge Clk);
      clear_a_load_b = 1'b1;
      sw             = v;
      @(negedge Clk);
      clear_a_load_b = 1'b0;
      mb             = v;
   endtask

   // Starts a multiply and returns once done is seen (or the bound expires).
   // cyc counts falling edges after the start edge.
   task automatic run_mult(input logic [N-1:0] m, input bit hold, input bit noise,
                           output int cyc, output int bcnt, output int fcnt, output int fat);
      @(negedge Clk);
      run            = 1'b1;
      sw             = m;
      clear_a_load_b = 1'b0;
      cyc  = 0;
      bcnt = 0;
      fcnt = 0;
      fat  = -1;
      while (!done && cyc < 40) begin
         @(negedge Clk);
         cyc++;
         if (busy)      bcnt++;
         if (addsub_fn) begin fcnt++; fat = cyc; end
         if (!hold) run = 1'b0;
         if (noise && !done) begin
            sw             = N'($urandom);
            clear_a_load_b = 1'($urandom);
         end
      end
      clear_a_load_b = 1'b0;
   endtask

   task automatic test_reset();
      Reset_n        = 1'b0;
      run            = 1'b0;
      clear_a_load_b = 1'b0;
      sw             = 8'hA5;
      #12;
      total++;
      if ({busy, done, addsub_fn, x_out} !== 4'b0) begin
         bad++;
         $display("FAIL reset_status: got busy/done/fn/x=%b expected 0000", {busy, done, addsub_fn, x_out});
      end
      total++;
      if ({a_out, b_out} !== 16'h0) begin
         bad++;
         $display("FAIL reset_ab: got %h expected 0000", {a_out, b_out});
      end
      total++;
      if ({addsub_a, addsub_b} !== 16'h0) begin
         bad++;
         $display("FAIL reset_adder_ops: got %h expected 0000", {addsub_a, addsub_b});
      end
      @(negedge Clk);
      Reset_n = 1'b1;
      mb      = '0;
   endtask

   task automatic test_directed();
      logic [N-1:0]   bv [3];
      logic [N-1:0]   mv [3];
      logic [2*N-1:0] ev [3];
      logic           xv [3];
      int cyc, bc, fc, fa;
      bv = '{8'h3B, 8'h3B, 8'hC5};
      mv = '{8'h07, 8'hF9, 8'h07};
      ev = '{16'h019D, 16'hFE63, 16'hFE63};
      xv = '{1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 3; i++) begin
         do_load_b(bv[i]);
         total++;
         if ({x_out, a_out, b_out} !== {1'b0, 8'h00, bv[i]}) begin
            bad++;
            $display("FAIL load_b[%0d]: got x:a:b=%h expected %h", i, {x_out, a_out, b_out}, {1'b0, 8'h00, bv[i]});
         end
         run_mult(mv[i], 1'b0, 1'b0, cyc, bc, fc, fa);
         total++;
         if (cyc !== 2*N + 1) begin
            bad++;
            $display("FAIL done_latency[%0d]: got %0d expected %0d", i, cyc, 2*N + 1);
         end
         total++;
         if (bc !== 2*N) begin
            bad++;
            $display("FAIL busy_cycles[%0d]: got %0d expected %0d", i, bc, 2*N);
         end
         total++;
         if (fc !== 1 || fa !== 2*N - 1) begin
            bad++;
            $display("FAIL fn_last_add[%0d]: got count=%0d at=%0d expected count=1 at=%0d", i, fc, fa, 2*N - 1);
         end
         total++;
         if ({a_out, b_out} !== ev[i]) begin
            bad++;
            $display("FAIL product[%0d]: got %h expected %h", i, {a_out, b_out}, ev[i]);
         end
         total++;
         if (x_out !== xv[i]) begin
            bad++;
            $display("FAIL x[%0d]: got %b expected %b", i, x_out, xv[i]);
         end
         @(negedge Clk);
         total++;
         if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_fall[%0d]: got %b expected 0", i, done);
         end
         mb = ev[i][N-1:0];
      end
   endtask

   task automatic test_back_to_back();
      int cyc, bc, fc, fa;
      do_load_b(8'h3B);
      run_mult(8'h07, 1'b0, 1'b0, cyc, bc, fc, fa);
      total++;
      if ({a_out, b_out} !== 16'h019D) begin
         bad++;
         $display("FAIL b2b_first: got %h expected 019d", {a_out, b_out});
      end
      @(negedge Clk);
      run_mult(8'h02, 1'b0, 1'b0, cyc, bc, fc, fa);
      total++;
      if (a_out !== 8'hFF || b_out !== 8'h3A || x_out !== 1'b1) begin
         bad++;
         $display("FAIL b2b_second: got x:a:b=%b:%h:%h expected 1:ff:3a", x_out, a_out, b_out);
      end
      @(negedge Clk);
      mb = b_out;
   endtask

   task automatic test_hold_run();
      int cyc, bc, fc, fa;
      do_load_b(8'h80);
      run_mult(8'h80, 1'b1, 1'b0, cyc, bc, fc, fa);
      total++;
      if ({x_out, a_out, b_out} !== {1'b0, 16'h4000} || cyc !== 2*N + 1) begin
         bad++;
         $display("FAIL extreme: got x:ab=%b:%h cyc=%0d expected 0:4000 cyc=%0d", x_out, {a_out, b_out}, cyc, 2*N + 1);
      end
      for (int i = 0; i < 10; i++) begin
         clear_a_load_b = 1'b1;
         sw             = N'($urandom);
         @(negedge Clk);
         total++;
         if (done !== 1'b1 || busy !== 1'b0 || {a_out, b_out} !== 16'h4000) begin
            bad++;
            $display("FAIL hold_done[%0d]: got done=%b busy=%b ab=%h expected 1 0 4000", i, done, busy, {a_out, b_out});
         end
      end
      clear_a_load_b = 1'b0;
      run            = 1'b0;
      @(negedge Clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL hold_release: got done=%b busy=%b expected 0 0", done, busy);
      end
      @(negedge Clk);
      total++;
      if (busy !== 1'b0 || {a_out, b_out} !== 16'h4000) begin
         bad++;
         $display("FAIL idle_after_hold: got busy=%b ab=%h expected 0 4000", busy, {a_out, b_out});
      end
      mb = 8'h00;
   endtask

   task automatic test_random();
      int             cyc, bc, fc, fa;
      logic [N-1:0]   m;
      logic [2*N-1:0] exp_p;
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 2) != 0) do_load_b(pick());
         m     = pick();
         exp_p = ref_mul(m, mb);
         run_mult(m, 1'($urandom), 1'($urandom), cyc, bc, fc, fa);
         total++;
         if ({a_out, b_out} !== exp_p || x_out !== exp_p[2*N-1] || cyc !== 2*N + 1) begin
            bad++;
            $display("FAIL rand[%0d] %h*%h: got x:ab=%b:%h cyc=%0d expected %b:%h cyc=%0d",
                     i, m, mb, x_out, {a_out, b_out}, cyc, exp_p[2*N-1], exp_p, 2*N + 1);
         end
         run = 1'b0;
         @(negedge Clk);
         total++;
         if (done !== 1'b0) begin
            bad++;
            $display("FAIL rand_done_fall[%0d]: got %b expected 0", i, done);
         end
         mb = exp_p[N-1:0];
      end
   endtask

   task automatic test_abort();
      int             cyc, bc, fc, fa;
      logic [2*N-1:0] exp_p;
      do_load_b(8'h3B);
      @(negedge Clk);
      run = 1'b1;
      sw  = 8'h07;
      repeat (5) begin
         @(negedge Clk);
         run = 1'b0;
      end
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL abort_busy: got %b expected 1", busy);
      end
      Reset_n = 1'b0;
      #1;
      total++;
      if ({busy, done, addsub_fn, x_out, a_out, b_out, addsub_a, addsub_b} !== '0) begin
         bad++;
         $display("FAIL abort_clear: got %h expected 0",
                  {busy, done, addsub_fn, x_out, a_out, b_out, addsub_a, addsub_b});
      end
      @(negedge Clk);
      Reset_n = 1'b1;
      mb      = '0;
      do_load_b(8'hC5);
      total++;
      if (b_out !== 8'hC5) begin
         bad++;
         $display("FAIL abort_reload: got %h expected c5", b_out);
      end
      // clear_a_load_b and sw toggle throughout the busy window.
      exp_p = ref_mul(8'h6D, 8'hC5);
      run_mult(8'h6D, 1'b0, 1'b1, cyc, bc, fc, fa);
      total++;
      if ({a_out, b_out} !== exp_p) begin
         bad++;
         $display("FAIL clear_ignored_busy: got %h expected %h", {a_out, b_out}, exp_p);
      end
      @(negedge Clk);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_hold_run();
      test_random();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule : tb_shift_add_mult_ctrl
`default_nettype wire
